// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
//   div_state_t   : controller states (IDLE, RUN, DONE)
//   div_qw        : quotient width = WIDTH + EXTRA
//   div_cnt_width : width of the RUN step counter, $clog2(QW/SPC + 1)
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int div_qw(input int width, input int extra);
        return width + extra;
    endfunction

    function automatic int div_cnt_width(input int qw, input int spc);
        return $clog2(qw / spc + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   a_i       [WIDTH:0]   partial remainder entering the step
//   bit_i                 next dividend bit shifted into the remainder
//   divisor_i [WIDTH-1:0] divisor
//   a_o       [WIDTH:0]   partial remainder leaving the step
//   q_o                   quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH:0]   a_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   a_o,
    output logic             q_o
);

    logic [WIDTH:0] a_shift;
    logic [WIDTH:0] trial;
    // The incoming remainder is always below the divisor, so its MSB is
    // never needed: the shifted value still fits in WIDTH+1 bits.
    logic           unused_a_msb;

    assign unused_a_msb = a_i[WIDTH];
    assign a_shift      = {a_i[WIDTH-1:0], bit_i};
    assign trial        = a_shift - {1'b0, divisor_i};

    // A set sign bit means the trial subtraction went negative: restore.
    assign q_o = ~trial[WIDTH];
    assign a_o = trial[WIDTH] ? a_shift : trial;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider for unsigned mantissas with valid/ready
// handshakes on both sides, divide-by-zero detection and a sticky flag.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake
//   dividend, divisor     unsigned operands, WIDTH bits
//   out_valid / out_ready result handshake
//   quotient  [QW-1:0]    floor((dividend << EXTRA) / divisor)
//   remainder [WIDTH-1:0] (dividend << EXTRA) mod divisor
//   sticky                remainder is non-zero
//   dbz                   divisor was zero (quotient forced to all ones)
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int EXTRA = 3,
    parameter int SPC   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                dividend,
    input  logic [WIDTH-1:0]                divisor,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [div_qw(WIDTH, EXTRA)-1:0] quotient,
    output logic [WIDTH-1:0]                remainder,
    output logic                            sticky,
    output logic                            dbz
);

    localparam int QW = div_qw(WIDTH, EXTRA);
    localparam int N  = QW / SPC;
    localparam int CW = div_cnt_width(QW, SPC);

    if ((QW % SPC) != 0) begin : g_spc_check
        $error("seq_restoring_divider: SPC must divide WIDTH+EXTRA");
    end

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [QW-1:0]    sh_q, sh_d;
    logic [QW-1:0]    qacc_q, qacc_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [QW-1:0]    quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             sticky_q, sticky_d;
    logic             dbz_q, dbz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Chain of SPC restoring steps; step 0 consumes the dividend MSB and
    // yields the most significant of this cycle's quotient bits.
    logic [SPC-1:0]    qbits;
    logic [WIDTH:0]    a_last;
    logic [QW+SPC-1:0] q_cat;
    logic [QW-1:0]     q_next;

    for (genvar gi = 0; gi < SPC; gi++) begin : g_step
        logic [WIDTH:0] a_in;
        logic [WIDTH:0] a_out;

        if (gi == 0) begin : g_first
            assign a_in = a_q;
        end else begin : g_chain
            assign a_in = g_step[gi-1].a_out;
        end

        div_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .a_i      (a_in),
            .bit_i    (sh_q[QW-1-gi]),
            .divisor_i(divisor_q),
            .a_o      (a_out),
            .q_o      (qbits[SPC-1-gi])
        );
    end

    assign a_last = g_step[SPC-1].a_out;
    // Concatenate then truncate so that SPC == QW is also well formed.
    assign q_cat  = {qacc_q, qbits};
    assign q_next = q_cat[QW-1:0];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        sh_d        = sh_q;
        qacc_d      = qacc_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        sticky_d    = sticky_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    divisor_d = divisor;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        sticky_d    = 1'b0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        a_d     = '0;
                        sh_d    = QW'(dividend) << EXTRA;
                        qacc_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                a_d    = a_last;
                sh_d   = sh_q << SPC;
                qacc_d = q_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = DONE;
                    quotient_d  = q_next;
                    remainder_d = a_last[WIDTH-1:0];
                    sticky_d    = |a_last[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the upcoming state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            sh_q        <= '0;
            qacc_q      <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            sticky_q    <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            sh_q        <= sh_d;
            qacc_q      <= qacc_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            sticky_q    <= sticky_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign sticky    = sticky_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: three divider instances (SPC = 1, 3, 9) driven by
// directed and randomized operations, checked against plain arithmetic.
module tb_seq_restoring_divider;

    localparam int W  = 24;
    localparam int EX = 3;
    localparam int QW = W + EX;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic [W-1:0]  dividend  [3];
    logic [W-1:0]  divisor   [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic [QW-1:0] quotient  [3];
    logic [W-1:0]  remainder [3];
    logic          sticky    [3];
    logic          dbz       [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int SPC_G = (gi == 0) ? 1 : ((gi == 1) ? 3 : 9);
        seq_restoring_divider #(
            .WIDTH(W),
            .EXTRA(EX),
            .SPC  (SPC_G)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .dividend (dividend[gi]),
            .divisor  (divisor[gi]),
            .out_valid(out_valid[gi]),
            .out_ready(out_ready[gi]),
            .quotient (quotient[gi]),
            .remainder(remainder[gi]),
            .sticky   (sticky[gi]),
            .dbz      (dbz[gi])
        );
    end

    function automatic int spc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 9;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
    task automatic start_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
        int w = 0;
        while (!in_ready[d] && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq("in_ready_wait", 64'(in_ready[d]), 64'd1);
        in_valid[d] = 1'b1;
        dividend[d] = a;
        divisor[d]  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        dividend[d] = W'($urandom);
        divisor[d]  = W'($urandom);
    endtask

    // Waits for the result from cycle 1 on and compares against arithmetic.
    task automatic wait_check(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
        int          lat = 1;
        int          exp_lat;
        logic [63:0] num;
        logic [63:0] eq;
        logic [63:0] er;
        while (!out_valid[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        num = 64'(a) << EX;
        if (b == '0) begin
            eq      = 64'h7FF_FFFF;
            er      = 64'd0;
            exp_lat = 1;
        end else begin
            eq      = num / 64'(b);
            er      = num % 64'(b);
            exp_lat = QW / spc_of(d) + 1;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("quotient", 64'(quotient[d]), eq);
        check_eq("remainder", 64'(remainder[d]), er);
        check_eq("sticky", 64'(sticky[d]), 64'(er != 0));
        check_eq("dbz", 64'(dbz[d]), 64'(b == '0));
        $display("op dut=%0d spc=%0d a=%h b=%h q=%h r=%h st=%0b dbz=%0b lat=%0d",
                 d, spc_of(d), a, b, quotient[d], remainder[d], sticky[d], dbz[d], lat);
    endtask

    task automatic finish_op(input int d, input int delay);
        repeat (delay) @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        check_eq("out_valid_drop", 64'(out_valid[d]), 64'd0);
    endtask

    task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b, input int delay);
        start_op(d, a, b);
        wait_check(d, a, b);
        finish_op(d, delay);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           mode;
        int           n_ops;

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            dividend[i]  = '0;
            divisor[i]   = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of every instance.
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_in_ready", 64'(in_ready[i]), 64'd1);
            check_eq("rst_out_valid", 64'(out_valid[i]), 64'd0);
            check_eq("rst_quotient", 64'(quotient[i]), 64'd0);
            check_eq("rst_remainder", 64'(remainder[i]), 64'd0);
            check_eq("rst_sticky", 64'(sticky[i]), 64'd0);
            check_eq("rst_dbz", 64'(dbz[i]), 64'd0);
        end

        // Directed cases.
        run_op(0, 24'h800000, 24'hC00000, 0);
        run_op(0, 24'hFFFFFF, 24'hFFFFFF, 0);
        run_op(1, 24'hFFFFFF, 24'hFFFFFF, 0);
        run_op(0, 24'h123456, 24'h000000, 0);
        run_op(2, 24'h000000, 24'h800001, 0);

        // Backpressure: result held while new operands wait on in_valid.
        start_op(0, 24'h800000, 24'hC00000);
        wait_check(0, 24'h800000, 24'hC00000);
        in_valid[0] = 1'b1;
        dividend[0] = 24'hC00000;
        divisor[0]  = 24'h800000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 64'(in_ready[0]), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid[0]), 64'd1);
            check_eq("bp_quotient", 64'(quotient[0]), 64'd5);
            check_eq("bp_remainder", 64'(remainder[0]), 64'h400000);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        check_eq("bp_ready_after", 64'(in_ready[0]), 64'd1);
        check_eq("bp_valid_after", 64'(out_valid[0]), 64'd0);
        check_eq("bp_hold_quotient", 64'(quotient[0]), 64'd5);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check_eq("bp_accepted", 64'(in_ready[0]), 64'd0);
        wait_check(0, 24'hC00000, 24'h800000);
        finish_op(0, 0);

        // Reset asserted in RUN cycle 10.
        start_op(0, 24'hFFFFFF, 24'h800001);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
        check_eq("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("mid_rst_quotient", 64'(quotient[0]), 64'd0);
        check_eq("mid_rst_remainder", 64'(remainder[0]), 64'd0);
        run_op(0, 24'hC00000, 24'h800000, 0);
        check_eq("post_rst_quotient", 64'(quotient[0]), 64'd12);

        // Randomized operands on each instance.
        for (int d = 0; d < 3; d++) begin
            n_ops = (d == 0) ? 400 : ((d == 1) ? 600 : 800);
            for (int k = 0; k < n_ops; k++) begin
                mode = int'($urandom_range(0, 9));
                ra   = W'($urandom);
                rb   = W'($urandom);
                case (mode)
                    0:       ra = '0;
                    1, 2, 3: begin
                        ra[W-1] = 1'b1;
                        rb[W-1] = 1'b1;
                    end
                    4:       rb = W'($urandom_range(1, 255));
                    5:       ra = W'($urandom_range(0, 255));
                    6:       rb = ra;
                    9:       rb = '0;
                    default: ;
                endcase
                run_op(d, ra, rb, int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
